// File: rtl/tmr_etr_cond.sv
// External-trigger conditioner: synchronises and glitch-filters capch_i, turns edges into
// one-cycle count/clear/load strobes per ETM, and captures the live count on each trigger.
module tmr_etr_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FLT_WIDTH   = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [2:0]           etm_i,
    input  logic [FLT_WIDTH-1:0] flt_i,
    input  logic                 capch_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 cap_rd_i,
    output logic                 lvl_o,
    output logic                 trg_cnt_o,
    output logic                 trg_clr_o,
    output logic                 trg_load_o,
    output logic [CNT_WIDTH-1:0] cap_val_o,
    output logic                 cap_vld_o,
    output logic                 cap_ovr_o
);

    localparam logic [2:0] ETM_RISE = 3'b001;
    localparam logic [2:0] ETM_FALL = 3'b010;
    localparam logic [2:0] ETM_CLER = 3'b011;
    localparam logic [2:0] ETM_LOAD = 3'b100;

    localparam int             PW         = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0]  PRIME_SEED = PW'(SYNC_STAGES);
    localparam logic [PW-1:0]  PRIME_DONE = PW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [PW-1:0]          r_prime;
    logic [FLT_WIDTH-1:0]   r_fcnt;
    logic                   r_lvl;
    logic                   r_lvl_d;
    logic                   r_trg_cnt;
    logic                   r_trg_clr;
    logic                   r_trg_load;
    logic [CNT_WIDTH-1:0]   r_cap_val;
    logic                   r_cap_vld;
    logic                   r_cap_ovr;

    logic w_s;
    logic w_rise;
    logic w_fall;
    logic w_cnt;
    logic w_clr;
    logic w_load;
    logic w_cap;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], capch_i};
    end

    // After reset, lvl and lvl_d are both seeded from the pin once the sync chain has
    // filled, so a pin already high at release does not look like an edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prime <= '0;
            r_fcnt  <= '0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
        end else if (r_prime != PRIME_DONE) begin
            r_prime <= r_prime + 1'b1;
            r_fcnt  <= '0;
            if (r_prime == PRIME_SEED) begin
                r_lvl   <= w_s;
                r_lvl_d <= w_s;
            end
        end else begin
            r_lvl_d <= r_lvl;
            if (w_s == r_lvl) begin
                r_fcnt <= '0;
            end else if (r_fcnt >= flt_i) begin
                r_lvl  <= w_s;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_rise = r_lvl & ~r_lvl_d;
    assign w_fall = ~r_lvl & r_lvl_d;

    always_comb begin
        w_cnt  = 1'b0;
        w_clr  = 1'b0;
        w_load = 1'b0;
        if (en_i) begin
            unique case (etm_i)
                ETM_RISE: w_cnt  = w_rise;
                ETM_FALL: w_cnt  = w_fall;
                ETM_CLER: w_clr  = w_rise;
                ETM_LOAD: w_load = w_rise;
                default:  ;
            endcase
        end
    end

    assign w_cap = w_cnt | w_clr | w_load;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_trg_cnt  <= 1'b0;
            r_trg_clr  <= 1'b0;
            r_trg_load <= 1'b0;
        end else begin
            r_trg_cnt  <= w_cnt;
            r_trg_clr  <= w_clr;
            r_trg_load <= w_load;
        end
    end

    // A read ack coinciding with a new capture consumes the old value, so no overrun.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cap_val <= '0;
            r_cap_vld <= 1'b0;
            r_cap_ovr <= 1'b0;
        end else if (w_cap) begin
            r_cap_val <= cnt_i;
            r_cap_vld <= 1'b1;
            r_cap_ovr <= cap_rd_i ? 1'b0 : (r_cap_ovr | r_cap_vld);
        end else if (cap_rd_i) begin
            r_cap_vld <= 1'b0;
            r_cap_ovr <= 1'b0;
        end
    end

    assign lvl_o      = r_lvl;
    assign trg_cnt_o  = r_trg_cnt;
    assign trg_clr_o  = r_trg_clr;
    assign trg_load_o = r_trg_load;
    assign cap_val_o  = r_cap_val;
    assign cap_vld_o  = r_cap_vld;
    assign cap_ovr_o  = r_cap_ovr;

endmodule

// File: tb/tb_tmr_etr_cond.sv
// Bench for tmr_etr_cond: expected strobes (kind, captured value, cycle) are queued when the
// pin is driven and matched against strobes recorded by a negedge monitor.
module tb_tmr_etr_cond;

    typedef struct {
        logic [2:0]  kind;   // {load, clr, cnt}
        logic [31:0] val;
        int          cyc;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        en_i = 1'b1;
    logic [2:0]  etm_i = 3'b001;
    logic [3:0]  flt_i = 4'd0;
    logic        capch_i = 1'b0;
    logic [31:0] cnt_i;
    logic        cap_rd_i = 1'b0;
    logic        lvl_o, trg_cnt_o, trg_clr_o, trg_load_o, cap_vld_o, cap_ovr_o;
    logic [31:0] cap_val_o;

    int          cyc = 0;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_cnt = 32'h0;
    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int          total = 0;
    int          bad = 0;

    assign cnt_i = use_fixed ? fixed_cnt : 32'h1000 + 32'(cyc);

    tmr_etr_cond #(.SYNC_STAGES(2), .FLT_WIDTH(4), .CNT_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .etm_i(etm_i), .flt_i(flt_i),
        .capch_i(capch_i), .cnt_i(cnt_i), .cap_rd_i(cap_rd_i), .lvl_o(lvl_o),
        .trg_cnt_o(trg_cnt_o), .trg_clr_o(trg_clr_o), .trg_load_o(trg_load_o),
        .cap_val_o(cap_val_o), .cap_vld_o(cap_vld_o), .cap_ovr_o(cap_ovr_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (trg_cnt_o || trg_clr_o || trg_load_o)
            obs_q.push_back('{kind: {trg_load_o, trg_clr_o, trg_cnt_o}, val: cap_val_o, cyc: cyc});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic read_ack();
        cap_rd_i = 1'b1;
        tick(1);
        cap_rd_i = 1'b0;
    endtask

    // pin driven now is sampled at the next edge; strobe follows SYNC+N+1 edges later
    task automatic push_exp(input logic [2:0] kind, input int lat);
        int c;
        c = cyc;
        exp_q.push_back('{kind: kind, val: use_fixed ? fixed_cnt : 32'h1000 + 32'(c + lat - 1),
                          cyc: c + lat});
    endtask

    task automatic test_reset();
        ev_t o;
        for (int i = 0; i < 6; i++) begin
            capch_i = i[0];
            tick(1);
            total++;
            if ({lvl_o, trg_cnt_o, trg_clr_o, trg_load_o, cap_vld_o, cap_ovr_o, cap_val_o} !== '0) begin
                bad++;
                $display("FAIL reset_outs: lvl=%b cnt=%b clr=%b load=%b vld=%b ovr=%b val=%h, want all 0",
                         lvl_o, trg_cnt_o, trg_clr_o, trg_load_o, cap_vld_o, cap_ovr_o, cap_val_o);
            end
        end
        capch_i = 1'b1; en_i = 1'b1; etm_i = 3'b001;
        rst_n_i = 1'b1;
        tick(2);
        total++;
        if (lvl_o !== 1'b0) begin bad++; $display("FAIL reset_lvl2: lvl=%b want 0", lvl_o); end
        tick(1);
        total++;
        if (lvl_o !== 1'b1) begin bad++; $display("FAIL reset_lvl3: lvl=%b want 1", lvl_o); end
        tick(6);
        total++;
        if (obs_q.size() != 0) begin
            o = obs_q[0];
            bad++;
            $display("FAIL reset_nostrobe: strobe kind=%b at cyc %0d, want none", o.kind, o.cyc);
        end
        obs_q.delete();
    endtask

    task automatic test_rise_fall();
        ev_t e, o;
        capch_i = 1'b0;
        tick(6);
        obs_q.delete();
        use_fixed = 1'b1; fixed_cnt = 32'h1234;
        push_exp(3'b001, 4);
        capch_i = 1'b1;
        tick(8);
        total++;
        if (cap_val_o !== 32'h1234 || cap_vld_o !== 1'b1 || cap_ovr_o !== 1'b0) begin
            bad++;
            $display("FAIL rise_cap: val=%h vld=%b ovr=%b want 1234/1/0", cap_val_o, cap_vld_o, cap_ovr_o);
        end
        read_ack();
        total++;
        if (cap_val_o !== 32'h1234 || cap_vld_o !== 1'b0 || cap_ovr_o !== 1'b0) begin
            bad++;
            $display("FAIL rd_clear: val=%h vld=%b ovr=%b want 1234/0/0", cap_val_o, cap_vld_o, cap_ovr_o);
        end
        use_fixed = 1'b0;
        etm_i = 3'b010;
        tick(1);
        push_exp(3'b001, 4);
        capch_i = 1'b0;
        tick(8);
        capch_i = 1'b1;
        tick(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL risefall_ev: no strobe, want kind=%b at cyc %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL risefall_ev: got kind=%b val=%h cyc=%0d want kind=%b val=%h cyc=%0d",
                             o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL risefall_extra: %0d extra strobes, want 0", obs_q.size());
        end
        obs_q.delete();
        read_ack();
    endtask

    task automatic test_filter();
        ev_t e, o;
        etm_i = 3'b001; flt_i = 4'd3;
        tick(2);
        capch_i = 1'b1;
        tick(3);
        capch_i = 1'b0;
        tick(10);
        total++;
        if (lvl_o !== 1'b0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL flt_short: lvl=%b strobes=%0d want 0/0", lvl_o, obs_q.size());
        end
        obs_q.delete();
        push_exp(3'b001, 7);
        capch_i = 1'b1;
        tick(4);
        capch_i = 1'b0;
        tick(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL flt_ev: no strobe, want kind=%b at cyc %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL flt_ev: got kind=%b val=%h cyc=%0d want kind=%b val=%h cyc=%0d",
                             o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL flt_extra: %0d extra strobes, want 0", obs_q.size());
        end
        obs_q.delete();
        flt_i = 4'd0;
        read_ack();
    endtask

    task automatic test_cler_load();
        ev_t e, o;
        logic [2:0] modes[2];
        logic [2:0] kinds[2];
        modes[0] = 3'b011; kinds[0] = 3'b010;
        modes[1] = 3'b100; kinds[1] = 3'b100;
        for (int m = 0; m < 2; m++) begin
            etm_i = modes[m];
            tick(1);
            for (int p = 0; p < 5; p++) begin
                push_exp(kinds[m], 4);
                capch_i = 1'b1;
                tick(3);
                capch_i = 1'b0;
                tick(4);
            end
            tick(4);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (obs_q.size() == 0) begin
                    bad++;
                    $display("FAIL cl_ev: no strobe, want kind=%b at cyc %0d", e.kind, e.cyc);
                end else begin
                    o = obs_q.pop_front();
                    if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
                        bad++;
                        $display("FAIL cl_ev: got kind=%b val=%h cyc=%0d want kind=%b val=%h cyc=%0d",
                                 o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
                    end
                end
            end
            total++;
            if (obs_q.size() != 0) begin
                bad++;
                $display("FAIL cl_extra: %0d extra strobes, want 0", obs_q.size());
            end
            obs_q.delete();
        end
        read_ack();
        etm_i = 3'b111;
        for (int p = 0; p < 2; p++) begin
            capch_i = 1'b1; tick(3);
            capch_i = 1'b0; tick(4);
        end
        total++;
        if (obs_q.size() != 0 || cap_vld_o !== 1'b0) begin
            bad++;
            $display("FAIL etm111: strobes=%0d vld=%b want 0/0", obs_q.size(), cap_vld_o);
        end
        obs_q.delete();
        en_i = 1'b0; etm_i = 3'b001;
        capch_i = 1'b1;
        tick(3);
        total++;
        if (lvl_o !== 1'b1) begin bad++; $display("FAIL dis_lvl_hi: lvl=%b want 1", lvl_o); end
        capch_i = 1'b0;
        tick(6);
        total++;
        if (lvl_o !== 1'b0 || obs_q.size() != 0 || cap_vld_o !== 1'b0) begin
            bad++;
            $display("FAIL dis_nostrobe: lvl=%b strobes=%0d vld=%b want 0/0/0", lvl_o, obs_q.size(), cap_vld_o);
        end
        obs_q.delete();
        en_i = 1'b1;
        tick(1);
    endtask

    task automatic test_capture();
        ev_t e, o;
        logic [31:0] v;
        etm_i = 3'b001;
        for (int p = 0; p < 2; p++) begin
            push_exp(3'b001, 4);
            capch_i = 1'b1; tick(3);
            capch_i = 1'b0; tick(4);
        end
        v = exp_q[1].val;
        total++;
        if (cap_vld_o !== 1'b1 || cap_ovr_o !== 1'b1 || cap_val_o !== v) begin
            bad++;
            $display("FAIL cap_ovr: vld=%b ovr=%b val=%h want 1/1/%h", cap_vld_o, cap_ovr_o, cap_val_o, v);
        end
        push_exp(3'b001, 4);
        v = exp_q[2].val;
        capch_i = 1'b1;
        tick(3);
        cap_rd_i = 1'b1;
        tick(1);
        cap_rd_i = 1'b0;
        total++;
        if (cap_vld_o !== 1'b1 || cap_ovr_o !== 1'b0 || cap_val_o !== v) begin
            bad++;
            $display("FAIL cap_rd_coinc: vld=%b ovr=%b val=%h want 1/0/%h", cap_vld_o, cap_ovr_o, cap_val_o, v);
        end
        capch_i = 1'b0;
        tick(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL cap_ev: no strobe, want kind=%b at cyc %0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL cap_ev: got kind=%b val=%h cyc=%0d want kind=%b val=%h cyc=%0d",
                             o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL cap_extra: %0d extra strobes, want 0", obs_q.size());
        end
        obs_q.delete();
        read_ack();
        total++;
        if (cap_vld_o !== 1'b0 || cap_ovr_o !== 1'b0 || cap_val_o !== v) begin
            bad++;
            $display("FAIL cap_rd_only: vld=%b ovr=%b val=%h want 0/0/%h", cap_vld_o, cap_ovr_o, cap_val_o, v);
        end
    endtask

    initial begin
        test_reset();
        test_rise_fall();
        test_filter();
        test_cler_load();
        test_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
